// File: rtl/dfp_compare_seq.sv
// dfp_compare_seq: sequential cohort-aware decimal floating-point comparator
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake; in_ready is high only while idle
//   quiet                 1 = only sNaN raises nanx, 0 = any NaN raises nanx
//   a_* / b_*             unpacked operands: sign, biased exponent, BCD
//                         significand (MSD at top), NaN/sNaN/infinity flags
//   out_valid / out_ready result handshake; result held until taken
//   o                     12-bit condition vector
//                         {lt,0,~un,~mlt,~le,~lt,~eq,un,mlt,le,lt,eq}
//   nanx                  invalid-operation flag for this result
module dfp_compare_seq #(
    parameter int N  = 34,
    parameter int EW = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            quiet,
    input  logic            a_sign,
    input  logic            b_sign,
    input  logic [EW-1:0]   a_exp,
    input  logic [EW-1:0]   b_exp,
    input  logic [4*N-1:0]  a_sig,
    input  logic [4*N-1:0]  b_sig,
    input  logic            a_nan,
    input  logic            b_nan,
    input  logic            a_snan,
    input  logic            b_snan,
    input  logic            a_inf,
    input  logic            b_inf,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [11:0]     o,
    output logic            nanx
);
    typedef enum logic [2:0] {S_IDLE, S_CLASS, S_ALIGN, S_CMP, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [4*N-1:0]  r_sig_l, r_sig_s;
    logic [EW-1:0]   r_d;
    logic            r_swap;
    logic            r_a_sign, r_b_sign, r_quiet;
    logic            r_a_nan, r_b_nan, r_a_snan, r_b_snan, r_a_inf, r_b_inf;
    logic [11:0]     r_o;
    logic            r_nanx;

    logic            w_swap, w_un, w_a_zero, w_b_zero, w_both_zero, w_special;
    logic            w_top, w_mgt, w_mlt, w_meq;
    logic            w_eq, w_lt, w_le, w_ml, w_nanx;
    logic [11:0]     w_o;

    // L is the operand with the larger exponent (a wins a tie)
    assign w_swap      = b_exp > a_exp;
    assign w_un        = r_a_nan | r_b_nan | r_a_snan | r_b_snan;
    assign w_a_zero    = !r_a_inf && ((r_swap ? r_sig_s : r_sig_l) == '0);
    assign w_b_zero    = !r_b_inf && ((r_swap ? r_sig_l : r_sig_s) == '0);
    assign w_both_zero = w_a_zero & w_b_zero;
    assign w_special   = w_un | r_a_inf | r_b_inf | w_a_zero | w_b_zero;
    assign w_top       = r_sig_l[4*N-1 -: 4] != 4'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // next state plus |a| vs |b| as decided in the current state
    always_comb begin
        w_next = r_state;
        w_mgt  = 1'b0;
        w_mlt  = 1'b0;
        case (r_state)
            S_IDLE:  w_next = in_valid ? S_CLASS : S_IDLE;
            S_CLASS: begin
                if (r_a_inf | r_b_inf) begin
                    w_mgt = r_a_inf & !r_b_inf;
                    w_mlt = r_b_inf & !r_a_inf;
                end else begin
                    w_mgt = w_b_zero & !w_a_zero;
                    w_mlt = w_a_zero & !w_b_zero;
                end
                w_next = w_special ? S_DONE : (r_d == '0 ? S_CMP : S_ALIGN);
            end
            S_ALIGN: begin
                // a nonzero top digit in L means L already outweighs S
                w_mgt  = w_top & !r_swap;
                w_mlt  = w_top & r_swap;
                w_next = w_top ? S_DONE : (r_d == EW'(1) ? S_CMP : S_ALIGN);
            end
            S_CMP: begin
                w_mgt  = r_swap ? (r_sig_l < r_sig_s) : (r_sig_l > r_sig_s);
                w_mlt  = r_swap ? (r_sig_l > r_sig_s) : (r_sig_l < r_sig_s);
                w_next = S_DONE;
            end
            S_DONE:  w_next = out_ready ? S_IDLE : S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // opposite signs are only equal when both are zero (-0 == +0)
    assign w_meq  = !w_mgt & !w_mlt;
    assign w_eq   = !w_un & w_meq & ((r_a_sign == r_b_sign) | w_both_zero);
    assign w_lt   = !w_un & ((r_a_sign != r_b_sign) ? (r_a_sign & !w_both_zero)
                                                    : (r_a_sign ? w_mgt : w_mlt));
    assign w_le   = w_lt | w_eq;
    assign w_ml   = !w_un & w_mlt;
    assign w_nanx = r_a_snan | r_b_snan | (!r_quiet & (r_a_nan | r_b_nan));
    assign w_o    = {w_lt, 1'b0, !w_un, !w_ml, !w_le, !w_lt, !w_eq,
                     w_un, w_ml, w_le, w_lt, w_eq};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig_l  <= '0;
            r_sig_s  <= '0;
            r_d      <= '0;
            r_swap   <= 1'b0;
            r_a_sign <= 1'b0;
            r_b_sign <= 1'b0;
            r_quiet  <= 1'b0;
            r_a_nan  <= 1'b0;
            r_b_nan  <= 1'b0;
            r_a_snan <= 1'b0;
            r_b_snan <= 1'b0;
            r_a_inf  <= 1'b0;
            r_b_inf  <= 1'b0;
            r_o      <= '0;
            r_nanx   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && in_valid) begin
                r_swap   <= w_swap;
                r_sig_l  <= w_swap ? b_sig : a_sig;
                r_sig_s  <= w_swap ? a_sig : b_sig;
                r_d      <= w_swap ? b_exp - a_exp : a_exp - b_exp;
                r_a_sign <= a_sign;
                r_b_sign <= b_sign;
                r_quiet  <= quiet;
                r_a_nan  <= a_nan;
                r_b_nan  <= b_nan;
                r_a_snan <= a_snan;
                r_b_snan <= b_snan;
                r_a_inf  <= a_inf;
                r_b_inf  <= b_inf;
            end
            if (r_state == S_ALIGN && !w_top) begin
                r_sig_l <= {r_sig_l[4*N-5:0], 4'h0};
                r_d     <= r_d - EW'(1);
            end
            // result captured once on entry to DONE and held there
            if (w_next == S_DONE && r_state != S_DONE) begin
                r_o    <= w_o;
                r_nanx <= w_nanx;
            end
        end
    end

    assign in_ready  = r_state == S_IDLE;
    assign out_valid = r_state == S_DONE;
    assign o         = r_o;
    assign nanx      = r_nanx;
endmodule

// File: tb/tb_dfp_compare_seq.sv
// tb_dfp_compare_seq: directed and random checks of dfp_compare_seq against a numeric model
module tb_dfp_compare_seq;
    localparam int N  = 34;
    localparam int EW = 12;

    typedef struct packed {
        logic           sign;
        logic [EW-1:0]  e;
        logic [4*N-1:0] s;
        logic           nan;
        logic           snan;
        logic           inf;
    } opnd_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic            quiet = 1'b0;
    logic            a_sign = 1'b0, b_sign = 1'b0;
    logic [EW-1:0]   a_exp = '0, b_exp = '0;
    logic [4*N-1:0]  a_sig = '0, b_sig = '0;
    logic            a_nan = 1'b0, b_nan = 1'b0, a_snan = 1'b0, b_snan = 1'b0;
    logic            a_inf = 1'b0, b_inf = 1'b0;
    logic            in_ready, out_valid, nanx;
    logic [11:0]     o;

    int errors = 0;
    int checks = 0;

    dfp_compare_seq #(.N(N), .EW(EW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .quiet(quiet), .a_sign(a_sign), .b_sign(b_sign), .a_exp(a_exp), .b_exp(b_exp),
        .a_sig(a_sig), .b_sig(b_sig), .a_nan(a_nan), .b_nan(b_nan),
        .a_snan(a_snan), .b_snan(b_snan), .a_inf(a_inf), .b_inf(b_inf),
        .out_valid(out_valid), .out_ready(out_ready), .o(o), .nanx(nanx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lz_of(input logic [4*N-1:0] s);
        for (int i = 0; i < N; i++) if (s[4*(N-1-i) +: 4] != 4'h0) return i;
        return N;
    endfunction

    function automatic int dig(input logic [4*N-1:0] s, input int k);
        return (k < N) ? int'(s[4*(N-1-k) +: 4]) : 0;
    endfunction

    // |a| vs |b| via position of the leading significant digit, then digit strings
    function automatic int mag_cmp(input logic [4*N-1:0] sa, input int ea,
                                   input logic [4*N-1:0] sb, input int eb);
        int la, lb, pa, pb, da, db;
        la = lz_of(sa);
        lb = lz_of(sb);
        if (la == N && lb == N) return 0;
        if (la == N) return -1;
        if (lb == N) return 1;
        pa = ea + N - la;
        pb = eb + N - lb;
        if (pa != pb) return pa > pb ? 1 : -1;
        for (int i = 0; i < N; i++) begin
            da = dig(sa, la + i);
            db = dig(sb, lb + i);
            if (da != db) return da > db ? 1 : -1;
        end
        return 0;
    endfunction

    function automatic void model(input opnd_t a, input opnd_t b, input logic q,
                                  output logic [11:0] eo, output logic en, output int el);
        logic un, az, bz, an, bn, eq, lt, le, ml;
        int c, m, d, lzl;
        un = a.nan | a.snan | b.nan | b.snan;
        en = a.snan | b.snan | (!q && un);
        az = !a.inf && a.s == '0;
        bz = !b.inf && b.s == '0;
        m  = mag_cmp(a.s, int'(a.e), b.s, int'(b.e));
        if (a.inf && b.inf) begin
            c = (a.sign == b.sign) ? 0 : (a.sign ? -1 : 1);
            ml = 1'b0;
        end else if (a.inf) begin
            c = a.sign ? -1 : 1;
            ml = 1'b0;
        end else if (b.inf) begin
            c = b.sign ? 1 : -1;
            ml = 1'b1;
        end else begin
            an = a.sign && !az;
            bn = b.sign && !bz;
            c  = (an != bn) ? (an ? -1 : 1) : (an ? -m : m);
            ml = m < 0;
        end
        eq = !un && c == 0;
        lt = !un && c < 0;
        le = eq | lt;
        ml = !un && ml;
        eo = {lt, 1'b0, !un, !ml, !le, !lt, !eq, un, ml, le, lt, eq};
        if (un || a.inf || b.inf || az || bz) el = 1;
        else begin
            d   = (a.e >= b.e) ? int'(a.e) - int'(b.e) : int'(b.e) - int'(a.e);
            lzl = lz_of(b.e > a.e ? b.s : a.s);
            el  = 2 + (d < lzl ? d : lzl);
        end
    endfunction

    function automatic opnd_t mk(input logic sg, input int e, input logic [4*N-1:0] s);
        opnd_t r;
        r = '0;
        r.sign = sg;
        r.e = EW'(e);
        r.s = s;
        return r;
    endfunction

    function automatic opnd_t rnd_op();
        opnd_t r;
        int nd;
        r = '0;
        r.sign = 1'($urandom_range(0, 1));
        r.e = ($urandom_range(0, 9) == 0) ? EW'($urandom) : EW'(100 + $urandom_range(0, 12));
        nd = $urandom_range(0, N);
        for (int k = 0; k < nd; k++) r.s[4*k +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 9) == 0) r.s = '0;
        case ($urandom_range(0, 19))
            0: r.nan = 1'b1;
            1: begin r.nan = 1'b1; r.snan = 1'b1; end
            2: r.inf = 1'b1;
            default: ;
        endcase
        return r;
    endfunction

    task automatic drive(input opnd_t a, input opnd_t b, input logic q);
        quiet = q;
        a_sign = a.sign; a_exp = a.e; a_sig = a.s; a_nan = a.nan; a_snan = a.snan; a_inf = a.inf;
        b_sign = b.sign; b_exp = b.e; b_sig = b.s; b_nan = b.nan; b_snan = b.snan; b_inf = b.inf;
        in_valid = 1'b1;
    endtask

    task automatic run(input string tag, input opnd_t a, input opnd_t b, input logic q, input int hold);
        logic [11:0] eo;
        logic en;
        int el, lat;
        model(a, b, q, eo, en, el);
        drive(a, b, q);
        check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'(el));
        check({tag, "/o"}, 32'(o), 32'(eo));
        check({tag, "/nanx"}, 32'(nanx), 32'(en));
        check({tag, "/busy"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "/hold_o"}, 32'(o), 32'(eo));
            check({tag, "/hold_nanx"}, 32'(nanx), 32'(en));
            check({tag, "/hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "/valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "/ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        opnd_t a, b;
        int k;
        #2;
        check("reset/o", 32'(o), 32'h0);
        check("reset/valid", 32'(out_valid), 32'd0);
        check("reset/nanx", 32'(nanx), 32'd0);
        check("reset/ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run("cohort", mk(1'b0, 101, 136'h1), mk(1'b0, 100, 136'h10), 1'b1, 0);
        check("cohort/const", 32'(o), 32'h345);
        run("zeros", mk(1'b0, 5, '0), mk(1'b1, 200, '0), 1'b1, 0);
        check("zeros/const", 32'(o), 32'h345);
        a = mk(1'b0, 100, '0); a.nan = 1'b1;
        run("qnan_quiet", a, mk(1'b0, 100, 136'h1), 1'b1, 0);
        check("qnan_quiet/const", 32'({nanx, o}), 32'h01F0);
        run("qnan_sig", a, mk(1'b0, 100, 136'h1), 1'b0, 0);
        check("qnan_sig/const", 32'({nanx, o}), 32'h11F0);
        a.snan = 1'b1;
        run("snan_quiet", a, mk(1'b0, 100, 136'h1), 1'b1, 0);
        check("snan_quiet/const", 32'({nanx, o}), 32'h11F0);
        run("sign", mk(1'b1, 100, 136'h5), mk(1'b0, 100, 136'h3), 1'b1, 0);
        check("sign/const", 32'(o), 32'hB26);
        run("early", mk(1'b0, 110, {4'h1, 132'h0}), mk(1'b0, 100, {N{4'h9}}), 1'b1, 0);
        check("early/const", 32'(o), 32'h3E0);
        run("backpressure", mk(1'b1, 100, 136'h7), mk(1'b1, 103, 136'h7), 1'b1, 10);

        drive(mk(1'b0, 120, 136'h1), mk(1'b0, 100, 136'h5), 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset/valid", 32'(out_valid), 32'd0);
        check("midreset/o", 32'(o), 32'h0);
        check("midreset/nanx", 32'(nanx), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midreset/ready", 32'(in_ready), 32'd1);
        run("after_reset", mk(1'b0, 101, 136'h1), mk(1'b0, 100, 136'h10), 1'b1, 0);

        for (int i = 0; i < 200; i++) begin
            a = rnd_op();
            b = rnd_op();
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, lz_of(a.s) < N ? lz_of(a.s) : N - 1);
                if (int'(a.e) >= k) begin
                    b = a;
                    b.sign = 1'($urandom_range(0, 1));
                    b.s = a.s << (4 * k);
                    b.e = a.e - EW'(k);
                end
            end
            run($sformatf("rand%0d", i), a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
